iir_out_quantizer: RTL and testbench

//  Output stage directly downstream of the 16th-order IIR filter. Takes the filter's
//  18-bit two's-complement result and decimates it by DECIM. Each kept sample is

---
 rtl/iir_out_quantizer.sv | 132 +++++++++++++
 tb/tb_iir_out_quantizer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/iir_out_quantizer.sv
// Decimating round/saturate output stage for the IIR filter, with a show-ahead output FIFO.
// Optional saturation event counter enabled by defining QUANT_SATCNT_EN.
module iir_out_quantizer #(
  parameter int WORD_IN    = 18,
  parameter int WORD_OUT   = 8,
  parameter int SHIFT      = 8,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WORD_IN-1:0]              in_data,
  input  logic                            in_valid,
  output logic [WORD_OUT-1:0]             out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            sat_flag,
  output logic                            overflow
`ifdef QUANT_SATCNT_EN
  ,
  output logic [15:0]                     sat_count
`endif
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [WORD_IN:0] RND = (WORD_IN+1)'(1) << (SHIFT-1);
  localparam logic [WORD_OUT-1:0] Q_MAX = {1'b0, {(WORD_OUT-1){1'b1}}};
  localparam logic [WORD_OUT-1:0] Q_MIN = {1'b1, {(WORD_OUT-1){1'b0}}};

  // Handshake: a word moves downstream on any cycle where out_valid and out_ready are
  // both high; out_valid never drops and out_data never changes until that happens.

  logic [PW-1:0]      phase;
  logic [WORD_IN-1:0] s1_data;
  logic               s1_valid;

  logic [WORD_OUT-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [LW-1:0]       level;

  logic                       keep;
  logic signed [WORD_IN:0]    rnd_sum;
  logic signed [WORD_IN:0]    shifted;
  logic [WORD_IN-WORD_OUT+1:0] hi_bits;
  logic                       pos_clip;
  logic                       neg_clip;
  logic [WORD_OUT-1:0]        q_data;
  logic                       full;
  logic                       push;
  logic                       pop;
  logic                       push_ok;

  assign keep = in_valid && (phase == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= '0;
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      if (in_valid)
        phase <= (phase == PW'(DECIM-1)) ? '0 : phase + PW'(1);
      s1_valid <= keep;
      if (keep)
        s1_data <= in_data;
    end
  end

  // One extra bit of headroom so adding the half-LSB cannot wrap.
  always_comb begin
    rnd_sum  = $signed({s1_data[WORD_IN-1], s1_data}) + $signed(RND);
    shifted  = rnd_sum >>> SHIFT;
    hi_bits  = shifted[WORD_IN:WORD_OUT-1];
    pos_clip = !hi_bits[WORD_IN-WORD_OUT+1] && (|hi_bits);
    neg_clip = hi_bits[WORD_IN-WORD_OUT+1] && !(&hi_bits);
    q_data   = shifted[WORD_OUT-1:0];
    if (pos_clip)
      q_data = Q_MAX;
    else if (neg_clip)
      q_data = Q_MIN;
  end

  assign full    = (level == LW'(FIFO_DEPTH));
  assign out_valid = (level != '0);
  assign pop     = out_valid && out_ready;
  assign push    = s1_valid;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      sat_flag <= s1_valid && (pos_clip || neg_clip);
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)
        level <= level + LW'(1);
      else if (pop && !push_ok)
        level <= level - LW'(1);
      if (push && full && !pop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst)
      mem[wr_ptr] <= q_data;
  end

  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign fifo_level = level;

`ifdef QUANT_SATCNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      sat_count <= '0;
    else if (sat_flag && (sat_count != 16'hFFFF))
      sat_count <= sat_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_iir_out_quantizer.sv
// Directed bench for iir_out_quantizer: expected words queued at stimulus time and
// compared by a negedge monitor on every accepted output word.
module tb_iir_out_quantizer;

  logic        clk;
  logic        rst;
  logic [17:0] in_data;
  logic        in_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fifo_level;
  logic        sat_flag;
  logic        overflow;
`ifdef QUANT_SATCNT_EN
  logic [15:0] sat_count;
`endif

  logic [7:0] exp_q[$];
  int n_tests;
  int n_fail;

  iir_out_quantizer dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fifo_level(fifo_level),
    .sat_flag(sat_flag),
    .overflow(overflow)
`ifdef QUANT_SATCNT_EN
    ,
    .sat_count(sat_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic strobe(input logic [17:0] v);
    in_data  = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic dummies();
    for (int i = 0; i < 3; i++) strobe(18'h00000);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {24'h0, out_data}, 32'hDEAD);
      end else begin
        check("out_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  typedef struct { logic [17:0] v; logic [7:0] q; logic s; } vec_t;
  vec_t vecs[4];

  initial begin
    n_tests = 0;
    n_fail = 0;
    in_data = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;

    do_reset();
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data", {24'h0, out_data}, 32'h0);
    check("rst_level", {29'h0, fifo_level}, 32'h0);
    check("rst_sat", {31'h0, sat_flag}, 32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);

    // 1: latency
    exp_q.push_back(8'h01);
    strobe(18'h00080);
    check("lat_t1_valid", {31'h0, out_valid}, 32'h0);
    tick();
    check("lat_t2_valid", {31'h0, out_valid}, 32'h1);
    check("lat_t2_data", {24'h0, out_data}, 32'h01);
    dummies();
    idle(3);

    // 2: rounding and saturation
    vecs[0] = '{18'h3FF80, 8'h00, 1'b0};
    vecs[1] = '{18'h0FFFF, 8'h7F, 1'b1};
    vecs[2] = '{18'h20000, 8'h80, 1'b1};
    vecs[3] = '{18'h07F7F, 8'h7F, 1'b0};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(vecs[i].q);
      strobe(vecs[i].v);
      tick();
      check("sat_flag", {31'h0, sat_flag}, {31'h0, vecs[i].s});
      dummies();
    end
    idle(3);

    // 3: decimation with back-to-back strobes
    do_reset();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h05);
    for (int i = 1; i <= 8; i++) begin
      in_data  = 18'(i) << 8;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    idle(4);
    check("decim_drained", exp_q.size(), 32'h0);

    // 4: overflow with consumer stalled
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) exp_q.push_back(8'(k));
      strobe(18'(k) << 8);
      dummies();
    end
    idle(2);
    check("ovf_level", {29'h0, fifo_level}, 32'h4);
    check("ovf_flag", {31'h0, overflow}, 32'h1);
    check("ovf_head", {24'h0, out_data}, 32'h01);
    out_ready = 1'b1;
    idle(6);
    check("ovf_drained", exp_q.size(), 32'h0);
    check("ovf_empty", {31'h0, out_valid}, 32'h0);
    check("ovf_sticky", {31'h0, overflow}, 32'h1);

    // 5: full FIFO with simultaneous push and pop
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(8'h10 + 8'(k));
      strobe((18'h10 + 18'(k)) << 8);
      dummies();
    end
    idle(2);
    check("full_level", {29'h0, fifo_level}, 32'h4);
    exp_q.push_back(8'h14);
    strobe(18'h14 << 8);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pp_level", {29'h0, fifo_level}, 32'h4);
    check("pp_overflow", {31'h0, overflow}, 32'h0);
    check("pp_head", {24'h0, out_data}, 32'h11);
    out_ready = 1'b1;
    idle(6);
    check("pp_drained", exp_q.size(), 32'h0);

    // 6: reset while a kept sample is in flight
    do_reset();
    strobe(18'h00100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("flush_valid", {31'h0, out_valid}, 32'h0);
      check("flush_level", {29'h0, fifo_level}, 32'h0);
      tick();
    end
    check("flush_data", {24'h0, out_data}, 32'h0);
    check("flush_sat", {31'h0, sat_flag}, 32'h0);

`ifdef QUANT_SATCNT_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h7F);
      strobe(18'h0FFFF);
      dummies();
    end
    idle(3);
    check("sat_count", {16'h0, sat_count}, 32'h3);
`endif

    idle(2);
    check("final_queue_empty", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
